// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide memory port controller.
// Pure declarations: no logic, no latency, no flow control.
// Consumers import everything with mem_ctrl_pkg::*.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic {
        GR_IF = 1'b0,
        GR_LS = 1'b1
    } grant_t;

    localparam logic [1:0] SZ_B       = 2'd0;
    localparam logic [1:0] SZ_H       = 2'd1;
    localparam logic [1:0] SZ_W       = 2'd2;
    localparam logic [1:0] IO_HI_DFLT = 2'b11;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM-side signal bundle for mem_ctrl.
// Wiring only: no latency.
// Requests are held by the master until the matching done pulse.
interface mem_ctrl_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic        ls_sext;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport slave (
        input  if_req, if_addr, ls_req, ls_wr, ls_size, ls_sext, ls_addr, ls_wdata, mem_din,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_wr, ls_size, ls_sext, ls_addr, ls_wdata, mem_din,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl_ext.sv
// Load result extension: byte/half zero- or sign-extended, word passed through.
// Latency: combinational.
// Backpressure: none.
module mem_ctrl_ext
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (size)
            SZ_B:    data = {{24{sext & raw[7]}},  raw[7:0]};
            SZ_H:    data = {{16{sext & raw[15]}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and LS loads/stores onto one byte-wide RAM/IO port.
// Latency: read done at accept+N+2, write done at accept+N+1 (N = 1/2/4 bytes).
// Backpressure: rdy=0 freezes everything; IO stores stall while io_buffer_full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_HI = IO_HI_DFLT
) (
    input logic        clk,
    input logic        rst,
    input logic        rdy,
    input logic        jp_wrong,
    input logic        io_buffer_full,
    mem_ctrl_if.slave  bus
);

    state_t      state_q, state_d;
    grant_t      cur_q, cur_d, last_q, last_d;
    logic [2:0]  k_q, k_d, n_q, n_d;
    logic [31:0] base_q, base_d, wdata_q, wdata_d, buf_q, buf_d;
    logic [31:0] mem_a_q, mem_a_d, if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [7:0]  dout_q, dout_d;
    logic        mem_wr_q, mem_wr_d, if_done_q, if_done_d, ls_done_q, ls_done_d;

    logic        io_stall, take_ls, take_if, idle_ok;
    logic [1:0]  cap_idx;
    logic [2:0]  k_inc, k_dec;
    logic [31:0] raw_new, ext_data;

    assign io_stall = (base_q[17:16] == IO_HI) && io_buffer_full;
    assign cap_idx  = k_q[1:0] - 2'd2;
    assign k_inc    = k_q + 3'd1;
    assign k_dec    = k_q - 3'd2;
    assign take_ls  = bus.ls_req && (!bus.if_req || last_q == GR_IF);
    assign take_if  = bus.if_req && !take_ls;
    // No accept while a done is showing: the requester still holds req that cycle.
    assign idle_ok  = !if_done_q && !ls_done_q;

    always_comb begin
        raw_new = buf_q;
        raw_new[8*cap_idx +: 8] = bus.mem_din;
    end

    mem_ctrl_ext u_ext (
        .size (size_q),
        .sext (sext_q),
        .raw  (raw_new),
        .data (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        k_d        = k_q;
        n_d        = n_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        size_d     = size_q;
        sext_d     = sext_q;
        dout_d     = dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        if (rdy) begin
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (idle_ok && take_ls && (bus.ls_wr || !jp_wrong)) begin
                        cur_d   = GR_LS;
                        last_d  = GR_LS;
                        base_d  = bus.ls_addr;
                        mem_a_d = bus.ls_addr;
                        n_d     = size_bytes(bus.ls_size);
                        size_d  = bus.ls_size;
                        sext_d  = bus.ls_sext;
                        wdata_d = bus.ls_wdata;
                        buf_d   = '0;
                        if (bus.ls_wr) begin
                            state_d  = ST_WRITE;
                            mem_wr_d = 1'b1;
                            dout_d   = bus.ls_wdata[7:0];
                            k_d      = 3'd0;
                        end else begin
                            state_d  = ST_READ;
                            k_d      = 3'd1;
                        end
                    end else if (idle_ok && take_if && !jp_wrong) begin
                        cur_d   = GR_IF;
                        last_d  = GR_IF;
                        base_d  = bus.if_addr;
                        mem_a_d = bus.if_addr;
                        n_d     = 3'd4;
                        size_d  = SZ_W;
                        sext_d  = 1'b0;
                        buf_d   = '0;
                        state_d = ST_READ;
                        k_d     = 3'd1;
                    end
                end
                ST_READ: begin
                    // k counts addresses issued; byte k-2 arrives on mem_din this cycle.
                    if (jp_wrong) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (k_q >= 3'd2) buf_d = raw_new;
                        if (k_q == n_q + 3'd1) begin
                            state_d = ST_IDLE;
                            if (cur_q == GR_IF) begin
                                if_done_d = 1'b1;
                                if_data_d = raw_new;
                            end else begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = ext_data;
                            end
                        end else begin
                            k_d = k_inc;
                            if (k_q < n_q) mem_a_d = base_q + {29'd0, k_q};
                        end
                    end
                end
                ST_WRITE: begin
                    if (!io_stall) begin
                        if (k_inc == n_q) begin
                            state_d   = ST_IDLE;
                            mem_wr_d  = 1'b0;
                            ls_done_d = 1'b1;
                        end else begin
                            k_d     = k_inc;
                            mem_a_d = base_q + {29'd0, k_inc};
                            dout_d  = wdata_q[8*k_inc[1:0] +: 8];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_q      <= GR_IF;
            last_q     <= GR_IF;
            k_q        <= '0;
            n_q        <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            mem_a_q    <= '0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            size_q     <= SZ_B;
            sext_q     <= 1'b0;
            dout_q     <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            k_q        <= k_d;
            n_q        <= n_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            dout_q     <= dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
        end
    end

    // While frozen mid-read, re-present the pending byte's address so mem_din
    // still carries that byte when rdy returns.
    assign bus.mem_a    = (!rdy && state_q == ST_READ && k_q >= 3'd2) ? base_q + {29'd0, k_dec}
                                                                      : mem_a_q;
    assign bus.mem_wr   = mem_wr_q && rdy && !io_stall;
    assign bus.mem_dout = dout_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model plus hand-computed expectations.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rdy, jp_wrong, io_buffer_full, ram_clr;
    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .jp_wrong       (jp_wrong),
        .io_buffer_full (io_buffer_full),
        .bus            (bus)
    );

    logic [7:0]  ram [0:255];
    logic [31:0] wlog_a[$];
    logic [7:0]  wlog_d[$];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else begin
            bus.mem_din <= ram[bus.mem_a[7:0]];
            if (bus.mem_wr) begin
                wlog_a.push_back(bus.mem_a);
                wlog_d.push_back(bus.mem_dout);
                if (bus.mem_a[17:16] != 2'b11) ram[bus.mem_a[7:0]] <= bus.mem_dout;
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ls_op(input logic wr, input logic [1:0] sz, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd);
        bus.ls_wr = wr; bus.ls_size = sz; bus.ls_sext = sext;
        bus.ls_addr = addr; bus.ls_wdata = wd; bus.ls_req = 1'b1;
        lat = -1; rd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.ls_done) begin lat = i; rd = bus.ls_rdata; break; end
        end
        bus.ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic if_op(input logic [31:0] addr, output int lat, output logic [31:0] rd);
        bus.if_addr = addr; bus.if_req = 1'b1;
        lat = -1; rd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.if_done) begin lat = i; rd = bus.if_data; break; end
        end
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, done_at, ifd, cnt;
        logic [31:0] rd, w;
        logic [3:0] order;

        rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0; io_buffer_full = 1'b0; ram_clr = 1'b1;
        bus.if_req = 0; bus.if_addr = '0; bus.ls_req = 0; bus.ls_wr = 0; bus.ls_size = SZ_B;
        bus.ls_sext = 0; bus.ls_addr = '0; bus.ls_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_wr",   32'(bus.mem_wr),   32'd0);
        check("rst_mem_a",    bus.mem_a,         32'd0);
        check("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        check("rst_if_done",  32'(bus.if_done),  32'd0);
        check("rst_ls_done",  32'(bus.ls_done),  32'd0);
        check("rst_if_data",  bus.if_data,       32'd0);
        check("rst_ls_rdata", bus.ls_rdata,      32'd0);
        rst = 1'b0; ram_clr = 1'b0;
        @(negedge clk);

        // Word store then sub-word loads of the same bytes.
        w = 32'hDEADBEEF;
        wlog_a.delete(); wlog_d.delete();
        ls_op(1'b1, SZ_W, 1'b0, 32'h20, w, lat, rd);
        check("st_w_lat", 32'(lat), 32'd5);
        check("st_w_cnt", 32'(wlog_a.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
            check("st_w_addr", wlog_a[i], 32'h20 + 32'(i));
            check("st_w_data", 32'(wlog_d[i]), 32'(w[8*i +: 8]));
        end
        ls_op(1'b0, SZ_B, 1'b1, 32'h22, '0, lat, rd);
        check("ld_bs_lat", 32'(lat), 32'd3);
        check("ld_bs_dat", rd, 32'hFFFFFFAD);
        ls_op(1'b0, SZ_H, 1'b1, 32'h22, '0, lat, rd);
        check("ld_hs_lat", 32'(lat), 32'd4);
        check("ld_hs_dat", rd, 32'hFFFFDEAD);
        ls_op(1'b0, SZ_H, 1'b0, 32'h20, '0, lat, rd);
        check("ld_hz_dat", rd, 32'h0000BEEF);
        ls_op(1'b0, SZ_B, 1'b0, 32'h23, '0, lat, rd);
        check("ld_bz_dat", rd, 32'h000000DE);
        ls_op(1'b0, SZ_W, 1'b1, 32'h20, '0, lat, rd);
        check("ld_w_lat", 32'(lat), 32'd6);
        check("ld_w_dat", rd, 32'hDEADBEEF);

        // Fetch with per-cycle address trace.
        ls_op(1'b1, SZ_B, 1'b0, 32'h1000, 32'h13, lat, rd);
        check("st_b_lat", 32'(lat), 32'd2);
        bus.if_addr = 32'h1000; bus.if_req = 1'b1; done_at = -1; rd = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i <= 4) check("if_addr", bus.mem_a, 32'h1000 + 32'(i - 1));
            if (i == 1) check("if_no_wr", 32'(bus.mem_wr), 32'd0);
            if (bus.if_done && done_at < 0) begin
                done_at = i; rd = bus.if_data; bus.if_req = 1'b0;
            end
        end
        bus.if_req = 1'b0;
        check("if_lat", 32'(done_at), 32'd6);
        check("if_dat", rd, 32'h00000013);
        if_op(32'h1020, lat, rd);
        check("if2_lat", 32'(lat), 32'd6);
        check("if2_dat", rd, 32'hDEADBEEF);

        // Both requesters held: grants alternate starting with LS.
        bus.ls_wr = 0; bus.ls_size = SZ_B; bus.ls_sext = 0; bus.ls_addr = 32'h20;
        bus.if_addr = 32'h1000; bus.ls_req = 1; bus.if_req = 1;
        order = '0; cnt = 0;
        for (int i = 0; i < 100 && cnt < 4; i++) begin
            @(negedge clk);
            if (bus.ls_done) begin order = {order[2:0], 1'b1}; cnt++; end
            if (bus.if_done) begin order = {order[2:0], 1'b0}; cnt++; end
        end
        bus.ls_req = 0; bus.if_req = 0;
        @(negedge clk);
        check("arb_cnt", 32'(cnt), 32'd4);
        check("arb_order", 32'(order), 32'b1010);

        // IO store stalled by a full UART buffer.
        wlog_a.delete(); wlog_d.delete();
        bus.ls_wr = 1; bus.ls_size = SZ_B; bus.ls_addr = 32'h30000; bus.ls_wdata = 32'h41;
        io_buffer_full = 1; bus.ls_req = 1; done_at = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i <= 4) check("io_nowr", 32'(bus.mem_wr), 32'd0);
            if (i == 4) begin
                io_buffer_full = 0;
                #1;
                check("io_wr",   32'(bus.mem_wr),   32'd1);
                check("io_a",    bus.mem_a,         32'h30000);
                check("io_dout", 32'(bus.mem_dout), 32'h41);
            end
            if (bus.ls_done && done_at < 0) begin done_at = i; bus.ls_req = 0; end
        end
        bus.ls_req = 0;
        check("io_lat", 32'(done_at), 32'd5);
        check("io_cnt", 32'(wlog_a.size()), 32'd1);

        // Flush during a fetch: no if_done, controller idle next cycle.
        bus.if_addr = 32'h1000; bus.if_req = 1; ifd = 0; done_at = -1; rd = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.if_done) ifd++;
            if (bus.ls_done && done_at < 0) begin done_at = i; rd = bus.ls_rdata; bus.ls_req = 0; end
            if (i == 5) check("jp_next_a", bus.mem_a, 32'h20);
            if (i == 4) jp_wrong = 0;
            if (i == 3) begin
                jp_wrong = 1; bus.if_req = 0;
                bus.ls_wr = 0; bus.ls_size = SZ_B; bus.ls_sext = 0; bus.ls_addr = 32'h20;
                bus.ls_req = 1;
            end
        end
        bus.ls_req = 0;
        check("jp_no_ifdone", 32'(ifd), 32'd0);
        check("jp_ld_lat", 32'(done_at), 32'd7);
        check("jp_ld_dat", rd, 32'h000000EF);

        // Flush in the accept cycle drops the fetch; it is re-accepted a cycle later.
        bus.if_addr = 32'h1000; bus.if_req = 1; jp_wrong = 1; lat = -1; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) jp_wrong = 0;
            if (bus.if_done) begin lat = i; rd = bus.if_data; break; end
        end
        bus.if_req = 0;
        @(negedge clk);
        check("jp_acc_lat", 32'(lat), 32'd7);
        check("jp_acc_dat", rd, 32'h00000013);

        // Stores complete through a flush.
        jp_wrong = 1;
        ls_op(1'b1, SZ_H, 1'b0, 32'h40, 32'h1234, lat, rd);
        jp_wrong = 0;
        check("jp_st_lat", 32'(lat), 32'd3);
        check("jp_st_b0", 32'(ram[8'h40]), 32'h34);
        check("jp_st_b1", 32'(ram[8'h41]), 32'h12);

        // rdy low for two cycles in the middle of a word fetch.
        bus.if_addr = 32'h1020; bus.if_req = 1; lat = -1; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 2) rdy = 0;
            if (i == 4) rdy = 1;
            if (bus.if_done) begin lat = i; rd = bus.if_data; break; end
        end
        bus.if_req = 0; rdy = 1;
        @(negedge clk);
        check("rdy_if_lat", 32'(lat), 32'd8);
        check("rdy_if_dat", rd, 32'hDEADBEEF);

        // rdy low during a store suppresses mem_wr.
        wlog_a.delete(); wlog_d.delete();
        bus.ls_wr = 1; bus.ls_size = SZ_B; bus.ls_addr = 32'h60; bus.ls_wdata = 32'h77;
        bus.ls_req = 1; done_at = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rdy = 0; #1;
                check("rdy_st_nowr", 32'(bus.mem_wr), 32'd0);
            end
            if (i == 2) rdy = 1;
            if (bus.ls_done && done_at < 0) begin done_at = i; bus.ls_req = 0; end
        end
        bus.ls_req = 0; rdy = 1;
        check("rdy_st_lat", 32'(done_at), 32'd3);
        check("rdy_st_cnt", 32'(wlog_a.size()), 32'd1);
        check("rdy_st_ram", 32'(ram[8'h60]), 32'h77);

        // Reset in the middle of a word store.
        bus.ls_wr = 1; bus.ls_size = SZ_W; bus.ls_addr = 32'h50; bus.ls_wdata = 32'hCAFEF00D;
        bus.ls_req = 1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 2) begin rst = 1; bus.ls_req = 0; end
        end
        check("rst2_mem_wr",   32'(bus.mem_wr),   32'd0);
        check("rst2_mem_a",    bus.mem_a,         32'd0);
        check("rst2_mem_dout", 32'(bus.mem_dout), 32'd0);
        check("rst2_ls_done",  32'(bus.ls_done),  32'd0);
        check("rst2_if_data",  bus.if_data,       32'd0);
        check("rst2_ls_rdata", bus.ls_rdata,      32'd0);
        rst = 0;
        @(negedge clk);
        check("rst2_b0", 32'(ram[8'h50]), 32'h0D);
        check("rst2_b2", 32'(ram[8'h52]), 32'h00);
        if_op(32'h1020, lat, rd);
        check("rst2_if_lat", 32'(lat), 32'd6);
        check("rst2_if_dat", rd, 32'hDEADBEEF);

        // Address increment wraps at 2^32.
        wlog_a.delete(); wlog_d.delete();
        ls_op(1'b1, SZ_H, 1'b0, 32'hFFFFFFFF, 32'hA55A, lat, rd);
        check("wrap_lat", 32'(lat), 32'd3);
        check("wrap_cnt", 32'(wlog_a.size()), 32'd2);
        if (wlog_a.size() == 2) begin
            check("wrap_a0", wlog_a[0], 32'hFFFFFFFF);
            check("wrap_a1", wlog_a[1], 32'h00000000);
            check("wrap_d1", 32'(wlog_d[1]), 32'hA5);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
